loop_gain_scheduler: RTL
========================

# loop_gain_scheduler

Gear-shifting controller for the ADPLL loop filter. It watches the phase-detector error word and schedules the proportional and integral gains that the loop filter consumes in dynamic mode. It starts with wide acquisition gains, narrows them as the error settles, and flags lock. Loss of lock returns it to the wide gains. It sits between the phase detector output and the loop filter `kp_i`/`ki_i` inputs, on the same `gen_clk_i`.

## Interface
- `ERROR_WIDTH`, 8: width of the signed error word.
- `KP_WIDTH`, 3: kp output width, same fixed-point format as the loop filter's kp.
- `KI_WIDTH`, 4: ki output width, same fixed-point format as the loop filter's ki.
- `KP_ACQ` / `KI_ACQ`, 3'b100 / 4'b0100: gains in ACQUIRE.
- `KP_TRK` / `KI_TRK`, 3'b010 / 4'b0010: gains in TRACK.
- `KP_LCK` / `KI_LCK`, 3'b001 / 4'b0001: gains in LOCKED.
- `LOCK_THRESH`, 2: an error with |error| ≤ this is "in window".
- `UNLOCK_THRESH`, 8: an error with |error| > this is "out of window".
- `LOCK_COUNT`, 16: consecutive in-window samples needed to advance one gear.
- `UNLOCK_COUNT`, 4: consecutive out-of-window samples needed to fall back to ACQUIRE.
- `SETTLE_CYCLES`, 8: samples ignored after any gear change.
- `CNT_WIDTH`, 8: width of the counters; must hold max(LOCK_COUNT, UNLOCK_COUNT, SETTLE_CYCLES).

Ports:
- `gen_clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: 0 forces ACQUIRE and holds it there.
- `error_i`, in, ERROR_WIDTH, signed: phase error, sampled every cycle.
- `kp_o`, out, KP_WIDTH: scheduled proportional gain.
- `ki_o`, out, KI_WIDTH: scheduled integral gain.
- `gear_o`, out, 2: current state; 0 = ACQUIRE, 1 = TRACK, 2 = LOCKED.
- `locked_o`, out, 1: high while in LOCKED.
- `gear_change_o`, out, 1: one-cycle pulse after every state change.

## Operation
- **Magnitude.** |error| is computed saturating: the most negative input maps to 2^(ERROR_WIDTH-1)-1. For ERROR_WIDTH = 8, -128 gives 127.
- **Settle.** On entry to any state, the settle counter loads SETTLE_CYCLES. While it is non-zero it decrements each cycle, lock_cnt and unlock_cnt are held at 0, and error_i is ignored.
- **Counting, when not settling:**
  - in-window sample: lock_cnt increments, unlock_cnt clears;
  - out-of-window sample: unlock_cnt increments, lock_cnt clears;
  - sample between the two thresholds: both counters clear.
- **States** (encoded on `gear_o`; the gain pair is a registered function of the state):
  - ACQUIRE: outputs KP_ACQ/KI_ACQ. Moves to TRACK when lock_cnt reaches LOCK_COUNT.
  - TRACK: outputs KP_TRK/KI_TRK. Moves to LOCKED when lock_cnt reaches LOCK_COUNT. Moves to ACQUIRE when unlock_cnt reaches UNLOCK_COUNT.
  - LOCKED: outputs KP_LCK/KI_LCK with `locked_o` = 1. Moves to ACQUIRE when unlock_cnt reaches UNLOCK_COUNT.
- **Only one gear per transition.** Counters clear on every transition.
- **enable_i low** has priority over all other transitions:
  - next state is ACQUIRE and all counters clear;
  - `gear_change_o` pulses only if the state was not already ACQUIRE;
  - the settle counter loads on that entry as usual.
- **Saturation.** Counters stop at their terminal value; they never wrap.

## Timing
- **Reset values** (asynchronous, while `reset_n_i` = 0): state ACQUIRE, `kp_o` = KP_ACQ, `ki_o` = KI_ACQ, `gear_o` = 0, `locked_o` = 0, `gear_change_o` = 0, all counters 0. No settle period follows reset.
- **Sampling.** `error_i` is registered at every rising edge.
- **Advance latency.** If the samples at edges N-LOCK_COUNT+1 through N are all in window and none of them falls inside a settle period, the state, gains, `gear_o` and `locked_o` all update at edge N. `gear_change_o` is high for exactly the cycle following edge N.
- **Fall-back latency.** Same rule with UNLOCK_COUNT.
- **Settle window.** After a transition at edge N, the samples at edges N+1 through N+SETTLE_CYCLES are ignored. The earliest next transition is at edge N+SETTLE_CYCLES+LOCK_COUNT, or N+SETTLE_CYCLES+UNLOCK_COUNT for a fall-back.
- **Reset mid-operation.** Asserting `reset_n_i` returns to reset values immediately, with no pulse on `gear_change_o`.
- **Glitch-free outputs.** All outputs come straight from registers, with no combinational path from inputs.

## Configuration
- **Macro `LGS_TRACK_GEAR_EN`.**
- **Defined:** the three-state machine above.
- **Undefined:**
  - TRACK does not exist; ACQUIRE advances directly to LOCKED after LOCK_COUNT in-window samples;
  - `gear_o` never reads 1;
  - the KP_TRK/KI_TRK parameters are ignored.

## Test plan
- **Reset.** Drive `reset_n_i` = 0, then release, with `error_i` = 50. Expect `kp_o` = 3'b100, `ki_o` = 4'b0100, `gear_o` = 0 and `locked_o` = 0 throughout.
- **Lock-in.** Hold `error_i` = 1 from reset release.
  - TRACK at edge 16, with `gear_change_o` high one cycle.
  - LOCKED at edge 16+8+16 = 40, with `kp_o` = 3'b001, `ki_o` = 4'b0001 and `locked_o` = 1.
  - Without the macro: LOCKED at edge 16.
- **Counter restart.** Drive 15 samples of `error_i` = -2, then one sample of 5, then 16 samples of 0. The advance to TRACK occurs only at the 16th zero, not earlier.
- **Unlock.** From LOCKED, apply `error_i` = -128 for 4 cycles. Expect ACQUIRE at the 4th edge, `locked_o` = 0 and one `gear_change_o` pulse. Repeat with 3 samples of -128 followed by 0, and expect LOCKED to be kept.
- **Enable.** From LOCKED, drop `enable_i` for 1 cycle. Expect ACQUIRE at the next edge and one pulse. Keep `enable_i` low for 20 cycles with `error_i` = 0, and expect no advance.
- **Asynchronous reset mid-operation.** Assert `reset_n_i` mid-cycle while in TRACK. Expect outputs to return to reset values before the next edge.

Source files
------------

// File: rtl/loop_gain_scheduler_if.sv
// loop_gain_scheduler_if
// Groups the scheduler's data-path signals: the phase-error sample and enable
// coming in from the phase-detector side, and the scheduled gains, gear and
// status going out to the loop filter.
//   enable_i      : 0 forces and holds ACQUIRE
//   error_i       : signed phase-error word, sampled every cycle
//   kp_o / ki_o   : scheduled proportional / integral gain
//   gear_o        : 0 = ACQUIRE, 1 = TRACK, 2 = LOCKED
//   locked_o      : high while in LOCKED
//   gear_change_o : one-cycle pulse after every state change
// Modports: master = phase-detector / controlling side, slave = scheduler.
interface loop_gain_scheduler_if #(
  parameter int ERROR_WIDTH = 8,
  parameter int KP_WIDTH    = 3,
  parameter int KI_WIDTH    = 4
);
  logic                          enable_i;
  logic signed [ERROR_WIDTH-1:0] error_i;
  logic [KP_WIDTH-1:0]           kp_o;
  logic [KI_WIDTH-1:0]           ki_o;
  logic [1:0]                    gear_o;
  logic                          locked_o;
  logic                          gear_change_o;

  modport master (
    output enable_i, error_i,
    input  kp_o, ki_o, gear_o, locked_o, gear_change_o
  );

  modport slave (
    input  enable_i, error_i,
    output kp_o, ki_o, gear_o, locked_o, gear_change_o
  );
endinterface

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler
// Gear-shifting gain scheduler for the ADPLL loop filter. Watches the phase
// error, starts with wide acquisition gains, narrows them as the error settles
// and flags lock; loss of lock falls back to the acquisition gains.
// Ports:
//   gen_clk_i : single clock
//   reset_n_i : asynchronous active-low reset
//   bus       : loop_gain_scheduler_if.slave (enable_i, error_i in;
//               kp_o, ki_o, gear_o, locked_o, gear_change_o out)
// Configuration macro: LGS_TRACK_GEAR_EN
//   defined   -> ACQUIRE -> TRACK -> LOCKED three-gear machine
//   undefined -> ACQUIRE advances straight to LOCKED; TRACK is never entered
module loop_gain_scheduler #(
  parameter int               ERROR_WIDTH   = 8,
  parameter int               KP_WIDTH      = 3,
  parameter int               KI_WIDTH      = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ     = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_ACQ     = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_TRK     = 3'b010,
  parameter logic [KI_WIDTH-1:0] KI_TRK     = 4'b0010,
  parameter logic [KP_WIDTH-1:0] KP_LCK     = 3'b001,
  parameter logic [KI_WIDTH-1:0] KI_LCK     = 4'b0001,
  parameter int               LOCK_THRESH   = 2,
  parameter int               UNLOCK_THRESH = 8,
  parameter int               LOCK_COUNT    = 16,
  parameter int               UNLOCK_COUNT  = 4,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               CNT_WIDTH     = 8
) (
  input logic               gen_clk_i,
  input logic               reset_n_i,
  loop_gain_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   LOCK_CNT_C   = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]   UNLOCK_CNT_C = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]   SETTLE_C     = CNT_WIDTH'(SETTLE_CYCLES);
  localparam logic [ERROR_WIDTH-1:0] LOCK_TH      = ERROR_WIDTH'(LOCK_THRESH);
  localparam logic [ERROR_WIDTH-1:0] UNLOCK_TH    = ERROR_WIDTH'(UNLOCK_THRESH);
  localparam logic [ERROR_WIDTH-1:0] MAG_MAX      = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
  localparam logic [ERROR_WIDTH-1:0] ERR_MIN      = {1'b1, {(ERROR_WIDTH-1){1'b0}}};

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [CNT_WIDTH-1:0]   unlock_cnt_reg, unlock_cnt_next;
  logic [CNT_WIDTH-1:0]   settle_reg, settle_next;
  logic [KP_WIDTH-1:0]    kp_reg, kp_next;
  logic [KI_WIDTH-1:0]    ki_reg, ki_next;
  logic                   locked_reg, locked_next;
  logic                   change_reg, change_next;

  logic [ERROR_WIDTH-1:0] err_mag;
  logic                   in_window, out_window;
  logic [CNT_WIDTH-1:0]   lock_inc, unlock_inc;

  // Saturating magnitude: the most negative code has no positive twin, so it
  // is clamped to the largest positive value instead of wrapping to itself.
  always_comb begin
    err_mag = bus.error_i;
    if (bus.error_i[ERROR_WIDTH-1]) begin
      if (bus.error_i == ERR_MIN) err_mag = MAG_MAX;
      else                        err_mag = -bus.error_i;
    end
  end

  assign in_window  = (err_mag <= LOCK_TH);
  assign out_window = (err_mag >  UNLOCK_TH);

  // Counters stop at their terminal value instead of wrapping.
  assign lock_inc   = (lock_cnt_reg   == LOCK_CNT_C)   ? lock_cnt_reg   : lock_cnt_reg + 1'b1;
  assign unlock_inc = (unlock_cnt_reg == UNLOCK_CNT_C) ? unlock_cnt_reg : unlock_cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    lock_cnt_next   = lock_cnt_reg;
    unlock_cnt_next = unlock_cnt_reg;
    settle_next     = settle_reg;

    if (!bus.enable_i) begin
      state_next      = ACQUIRE;
      lock_cnt_next   = '0;
      unlock_cnt_next = '0;
      settle_next     = (settle_reg != '0) ? settle_reg - 1'b1 : '0;
    end else if (settle_reg != '0) begin
      settle_next     = settle_reg - 1'b1;
      lock_cnt_next   = '0;
      unlock_cnt_next = '0;
    end else begin
      // Samples between the two thresholds clear both counters.
      lock_cnt_next   = in_window  ? lock_inc   : '0;
      unlock_cnt_next = out_window ? unlock_inc : '0;
      // The current sample counts toward the threshold, so the gear moves on
      // the same edge that registers the LOCK_COUNT-th in-window sample.
      case (state_reg)
        ACQUIRE: begin
          if (in_window && lock_inc == LOCK_CNT_C) begin
`ifdef LGS_TRACK_GEAR_EN
            state_next = TRACK;
`else
            state_next = LOCKED;
`endif
          end
        end
`ifdef LGS_TRACK_GEAR_EN
        TRACK: begin
          if (in_window && lock_inc == LOCK_CNT_C)
            state_next = LOCKED;
          else if (out_window && unlock_inc == UNLOCK_CNT_C)
            state_next = ACQUIRE;
        end
`endif
        LOCKED: begin
          if (out_window && unlock_inc == UNLOCK_CNT_C)
            state_next = ACQUIRE;
        end
        default: state_next = ACQUIRE;
      endcase
    end

    // Every state entry restarts the counters and opens a settle window.
    if (state_next != state_reg) begin
      lock_cnt_next   = '0;
      unlock_cnt_next = '0;
      settle_next     = SETTLE_C;
    end

    change_next = (state_next != state_reg);
    locked_next = (state_next == LOCKED);
    kp_next     = KP_ACQ;
    ki_next     = KI_ACQ;
    case (state_next)
      TRACK:   begin kp_next = KP_TRK; ki_next = KI_TRK; end
      LOCKED:  begin kp_next = KP_LCK; ki_next = KI_LCK; end
      default: begin kp_next = KP_ACQ; ki_next = KI_ACQ; end
    endcase
  end

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ACQUIRE;
      lock_cnt_reg   <= '0;
      unlock_cnt_reg <= '0;
      settle_reg     <= '0;
      kp_reg         <= KP_ACQ;
      ki_reg         <= KI_ACQ;
      locked_reg     <= 1'b0;
      change_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lock_cnt_reg   <= lock_cnt_next;
      unlock_cnt_reg <= unlock_cnt_next;
      settle_reg     <= settle_next;
      kp_reg         <= kp_next;
      ki_reg         <= ki_next;
      locked_reg     <= locked_next;
      change_reg     <= change_next;
    end
  end

  assign bus.kp_o          = kp_reg;
  assign bus.ki_o          = ki_reg;
  assign bus.gear_o        = state_reg;
  assign bus.locked_o      = locked_reg;
  assign bus.gear_change_o = change_reg;

endmodule
